serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq.sv | 81 ++++++++
 tb/tb_serial_add_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial operand sequencer and result collector for an external 1-bit full_adder.
// Define SERIAL_ADD_OVF_EN to add the ovf_out signed-overflow output.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_out,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             run;
  assign run       = state == RUN;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign fa_a      = run & a_sh[0];
  assign fa_b      = run & b_sh[0];
  assign fa_cin    = run & carry_q;
  // sum bits refill a_sh from the top, so after WIDTH shifts it holds the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      carry_q  <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh    <= op_a;
          b_sh    <= op_b;
          carry_q <= cin_in;
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          a_sh    <= {fa_sum, a_sh[WIDTH-1:1]};
          b_sh    <= b_sh >> 1;
          carry_q <= fa_cout;
          cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            sum_out  <= {fa_sum, a_sh[WIDTH-1:1]};
            cout_out <= fa_cout;
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_out <= 1'b0;
    else if (run && cnt == LAST) ovf_out <= carry_q ^ fa_cout;
  end
`endif
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed checks of serial_add_seq driving a behavioural full adder.
module tb_serial_add_seq;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] op_a = '0, op_b = '0, sum_out;
  logic       cin_in = 1'b0, cout_out;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf_out;
`endif
  int         vectors = 0, miscompares = 0;
  logic [7:0] fa_a_seq, fa_b_seq;
  int         lat;

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_out(ovf_out),
`endif
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
    chk(tag, ovf_out, exp);
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // Accept one operand pair, walk the RUN phase, and check the result in DONE.
  task automatic start_op(input string tag, input logic [7:0] a, b, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo);
    op_a = a; op_b = b; cin_in = c; in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    lat = 0; fa_a_seq = '0; fa_b_seq = '0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) begin
        fa_a_seq[lat] = fa_a;
        fa_b_seq[lat] = fa_b;
      end
      tick;
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_sum"}, sum_out, es);
    chk({tag, "_cout"}, cout_out, ec);
    chk_ovf({tag, "_ovf"}, eo);
    chk({tag, "_fa_idle"}, {fa_a, fa_b, fa_cin}, 0);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_cout", {cout_out, sum_out}, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    chk_ovf("rst_ovf", 1'b0);
    rst_n = 1'b1;
    tick;

    start_op("t1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    finish_op("t1");

    start_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    finish_op("t2");

    start_op("t3", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("t3_fa_a_seq", fa_a_seq, 8'h5A);
    chk("t3_fa_b_seq", fa_b_seq, 8'hA5);
    finish_op("t3");

    start_op("t4", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    finish_op("t4");

    start_op("t5", 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op_a = 8'hF0 + 8'(i); op_b = 8'hFF; cin_in = 1'b1; in_valid = 1'b1;
      tick;
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_sum", {cout_out, sum_out}, 9'h078);
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_fa", {fa_a, fa_b, fa_cin}, 0);
    end
    in_valid = 1'b0;
    finish_op("t5");
    tick;
    chk("t5_not_captured", {in_ready, out_valid}, 2'b10);
    chk("t5_sum_kept", {cout_out, sum_out}, 9'h078);

    op_a = 8'hFF; op_b = 8'hFF; cin_in = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    chk("t6_mid_run_fa_cin", fa_cin, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_sum_cout", {cout_out, sum_out}, 0);
    chk("t6_rst_fa", {fa_a, fa_b, fa_cin}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6_post_rst_in_ready", in_ready, 1);
    start_op("t6", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    finish_op("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
